// File: rtl/nios_dbg_pkg.sv
// Shared definitions for the Nios II debug command sequencer.
//   dbg_op_t     : 4-bit action op codes, one per take_action_*/take_no_action_* strobe.
//   seq_state_t  : sequencer FSM states.
//   is_ocimem()  : true for ops that need a monitor completion before the next issue.
package nios_dbg_pkg;

  localparam int OP_W    = 4;
  localparam int NUM_OPS = 10;

  typedef enum logic [OP_W-1:0] {
    OP_BRK_A     = 4'd0,
    OP_BRK_B     = 4'd1,
    OP_BRK_C     = 4'd2,
    OP_OCIMEM_A  = 4'd3,
    OP_OCIMEM_B  = 4'd4,
    OP_TRACECTRL = 4'd5,
    OP_NBRK_A    = 4'd6,
    OP_NBRK_B    = 4'd7,
    OP_NBRK_C    = 4'd8,
    OP_NOCIMEM_A = 4'd9
  } dbg_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_MON
  } seq_state_t;

  function automatic logic is_ocimem(input dbg_op_t op);
    return (op == OP_OCIMEM_A) || (op == OP_OCIMEM_B) || (op == OP_NOCIMEM_A);
  endfunction

endpackage

// File: rtl/nios_dbg_cmd_fifo.sv
// Synchronous FIFO holding {op, jdo} command entries.
//   clk, reset_n          : clock, async active-low reset (pointers/count only)
//   push, push_data       : write request; accepted when not full or when popping
//   pop, pop_data         : read request; pop_data shows the head combinationally
//   full, empty, count    : occupancy, count is clog2(DEPTH)+1 bits
module nios_dbg_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 42
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop && !empty;
  // A simultaneous pop frees the slot being written, so a full FIFO still accepts.
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  // NOTE: storage is not reset; entries are only read after being written, so
  // only pointers and count need a reset value.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nios_dbg_cmd_sequencer.sv
// Nios II debug command sequencer (sysclk side of the debug slave).
// Captures one-cycle take_action_*/take_no_action_* strobes with jdo, queues
// them, and issues them in order on a valid/ready channel to the OCI monitor.
// OCI memory ops wait for monitor_ready/monitor_error (with timeout).
//   clk, reset_n              : clock, async active-low reset
//   jdo, take_*               : captured payload and action strobes
//   cmd_valid/op/data, ready  : command channel
//   monitor_ready/error       : completion of OCI memory ops
//   clr_status                : clears sticky flags (and stats)
//   busy, *_sticky            : status
// Optional: define NIOS_DBG_SEQ_STATS_EN to add stat_issued/stat_dropped/stat_tmo.
module nios_dbg_cmd_sequencer
  import nios_dbg_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int JDO_W       = 38,
  parameter int TIMEOUT_CYC = 1023,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_break_a,
  input  logic              take_action_break_b,
  input  logic              take_action_break_c,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_action_tracectrl,
  input  logic              take_no_action_break_a,
  input  logic              take_no_action_break_b,
  input  logic              take_no_action_break_c,
  input  logic              take_no_action_ocimem_a,
  output logic              cmd_valid,
  output logic [OP_W-1:0]   cmd_op,
  output logic [JDO_W-1:0]  cmd_data,
  input  logic              cmd_ready,
  input  logic              monitor_ready,
  input  logic              monitor_error,
  input  logic              clr_status,
`ifdef NIOS_DBG_SEQ_STATS_EN
  output logic [CNT_W-1:0]  stat_issued,
  output logic [CNT_W-1:0]  stat_dropped,
  output logic [CNT_W-1:0]  stat_tmo,
`endif
  output logic              busy,
  output logic              ovf_sticky,
  output logic              err_sticky,
  output logic              tmo_sticky
);

  localparam int FW = OP_W + JDO_W;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  // Strobe vector indexed by op code.
  logic [NUM_OPS-1:0] strobes;
  assign strobes = {take_no_action_ocimem_a, take_no_action_break_c, take_no_action_break_b,
                    take_no_action_break_a, take_action_tracectrl, take_action_ocimem_b,
                    take_action_ocimem_a, take_action_break_c, take_action_break_b,
                    take_action_break_a};

  dbg_op_t sel_op;
  logic    any_strobe;
  logic    multi_strobe;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel_op = OP_BRK_A;
    for (int i = NUM_OPS - 1; i >= 0; i--) begin
      if (strobes[i]) sel_op = dbg_op_t'(OP_W'(i));
    end
  end

  assign any_strobe   = |strobes;
  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi_strobe = |(strobes & (strobes - NUM_OPS'(1)));

  logic [FW-1:0]              fifo_head;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                       fifo_pop;
  logic                       drop_full;

  seq_state_t state_q, state_d;

  assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
  assign drop_full = any_strobe && fifo_full && !fifo_pop;

  nios_dbg_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (any_strobe),
    .push_data ({sel_op, jdo}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  dbg_op_t          cmd_op_q;
  logic [JDO_W-1:0] cmd_data_q;
  logic [TW-1:0]    tmo_cnt;
  logic             tmo_hit;
  logic             err_hit;
  logic             accept;

  assign accept  = (state_q == ST_ISSUE) && cmd_ready;
  assign err_hit = (state_q == ST_WAIT_MON) && monitor_error;
  assign tmo_hit = (state_q == ST_WAIT_MON) && !monitor_error && !monitor_ready &&
                   (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (!fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE:    if (cmd_ready) state_d = is_ocimem(cmd_op_q) ? ST_WAIT_MON : ST_IDLE;
      ST_WAIT_MON: if (monitor_error || monitor_ready || tmo_hit) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cmd_op_q   <= OP_BRK_A;
      cmd_data_q <= '0;
      tmo_cnt    <= '0;
    end else begin
      state_q <= state_d;
      if (fifo_pop) begin
        cmd_op_q   <= dbg_op_t'(fifo_head[FW-1 -: OP_W]);
        cmd_data_q <= fifo_head[JDO_W-1:0];
      end
      tmo_cnt <= (state_q == ST_WAIT_MON) ? tmo_cnt + TW'(1) : '0;
    end
  end

  // Set wins over a same-cycle clear so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_sticky <= 1'b0;
      err_sticky <= 1'b0;
      tmo_sticky <= 1'b0;
    end else begin
      if (multi_strobe || drop_full) ovf_sticky <= 1'b1;
      else if (clr_status)           ovf_sticky <= 1'b0;
      if (err_hit)                   err_sticky <= 1'b1;
      else if (clr_status)           err_sticky <= 1'b0;
      if (tmo_hit)                   tmo_sticky <= 1'b1;
      else if (clr_status)           tmo_sticky <= 1'b0;
    end
  end

`ifdef NIOS_DBG_SEQ_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_issued  <= '0;
      stat_dropped <= '0;
      stat_tmo     <= '0;
    end else if (clr_status) begin
      stat_issued  <= '0;
      stat_dropped <= '0;
      stat_tmo     <= '0;
    end else begin
      if (accept && stat_issued != '1) stat_issued <= stat_issued + CNT_W'(1);
      if ((multi_strobe || drop_full) && stat_dropped != '1) stat_dropped <= stat_dropped + CNT_W'(1);
      if (tmo_hit && stat_tmo != '1) stat_tmo <= stat_tmo + CNT_W'(1);
    end
  end
`endif

  assign cmd_valid = (state_q == ST_ISSUE);
  assign cmd_op    = cmd_op_q;
  assign cmd_data  = cmd_data_q;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_nios_dbg_cmd_sequencer.sv
// Self-checking bench for nios_dbg_cmd_sequencer (FIFO_DEPTH=4, TIMEOUT_CYC=8).
// Expected commands are queued when strobes are driven and compared in order
// whenever the DUT completes a cmd_valid/cmd_ready handshake.
module tb_nios_dbg_cmd_sequencer;

  localparam int JDO_W = 38;

  typedef struct packed {
    logic [3:0]       op;
    logic [JDO_W-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [JDO_W-1:0] jdo;
  logic [9:0]       stb;
  logic             cmd_valid;
  logic [3:0]       cmd_op;
  logic [JDO_W-1:0] cmd_data;
  logic             cmd_ready;
  logic             monitor_ready;
  logic             monitor_error;
  logic             clr_status;
  logic             busy;
  logic             ovf_sticky;
  logic             err_sticky;
  logic             tmo_sticky;
`ifdef NIOS_DBG_SEQ_STATS_EN
  logic [15:0]      stat_issued;
  logic [15:0]      stat_dropped;
  logic [15:0]      stat_tmo;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  nios_dbg_cmd_sequencer #(
    .FIFO_DEPTH  (4),
    .JDO_W       (JDO_W),
    .TIMEOUT_CYC (8),
    .CNT_W       (16)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_break_a     (stb[0]),
    .take_action_break_b     (stb[1]),
    .take_action_break_c     (stb[2]),
    .take_action_ocimem_a    (stb[3]),
    .take_action_ocimem_b    (stb[4]),
    .take_action_tracectrl   (stb[5]),
    .take_no_action_break_a  (stb[6]),
    .take_no_action_break_b  (stb[7]),
    .take_no_action_break_c  (stb[8]),
    .take_no_action_ocimem_a (stb[9]),
    .cmd_valid               (cmd_valid),
    .cmd_op                  (cmd_op),
    .cmd_data                (cmd_data),
    .cmd_ready               (cmd_ready),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .clr_status              (clr_status),
`ifdef NIOS_DBG_SEQ_STATS_EN
    .stat_issued             (stat_issued),
    .stat_dropped            (stat_dropped),
    .stat_tmo                (stat_tmo),
`endif
    .busy                    (busy),
    .ovf_sticky              (ovf_sticky),
    .err_sticky              (err_sticky),
    .tmo_sticky              (tmo_sticky)
  );

  // Scoreboard: every accepted command must be the oldest expected one.
  always @(negedge clk) begin
    if (reset_n && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL issue_unexpected: got op=%0d data=%h, required no command", cmd_op, cmd_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({cmd_op, cmd_data} !== {e.op, e.data}) begin
          miscompares++;
          $display("FAIL issue_order: got op=%0d data=%h, required op=%0d data=%h",
                   cmd_op, cmd_data, e.op, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe; returns 1ns after the capturing edge.
  task automatic pulse(input logic [9:0] v, input logic [JDO_W-1:0] d);
    stb = v;
    jdo = d;
    tick();
    stb = '0;
    jdo = {$urandom, $urandom};
  endtask

  task automatic expect_cmd(input logic [3:0] op, input logic [JDO_W-1:0] d);
    exp_t e;
    e.op   = op;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", busy, budget);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    chk("reset_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("reset_cmd_op", 64'(cmd_op), 64'd0);
    chk("reset_cmd_data", 64'(cmd_data), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_stickies", 64'({ovf_sticky, err_sticky, tmo_sticky}), 64'd0);
  endtask

  task automatic test_latency();
    cmd_ready = 1'b1;
    expect_cmd(4'd0, 38'h2A);
    pulse(10'b1, 38'h2A);                   // strobe cycle N
    @(negedge clk);
    chk("lat_valid_n1", 64'(cmd_valid), 64'd0);
    tick();
    @(negedge clk);                         // cycle N+2
    chk("lat_valid_n2", 64'(cmd_valid), 64'd1);
    chk("lat_op_n2", 64'(cmd_op), 64'd0);
    chk("lat_data_n2", 64'(cmd_data), 64'h2A);
    tick();
    @(negedge clk);                         // cycle N+3
    chk("lat_busy_n3", 64'(busy), 64'd0);
  endtask

  task automatic test_ocimem_wait();
    cmd_ready = 1'b1;
    expect_cmd(4'd3, 38'h1_2345_6789);
    expect_cmd(4'd1, 38'h0BEEF);
    pulse(10'b1 << 3, 38'h1_2345_6789);     // N
    pulse(10'b1 << 1, 38'h0BEEF);           // N+1, now in N+2 (ISSUE)
    tick();                                 // N+3, WAIT_MON
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mon_wait_busy", 64'({busy, cmd_valid}), 64'b10);
      tick();
    end
    monitor_ready = 1'b1;                   // N+7
    tick();
    monitor_ready = 1'b0;                   // N+8, IDLE pops BRK_B
    @(negedge clk);
    chk("mon_idle_valid", 64'(cmd_valid), 64'd0);
    tick();
    @(negedge clk);                         // N+9, BRK_B issued
    chk("mon_next_valid", 64'({cmd_valid, cmd_op}), 64'({1'b1, 4'd1}));
    wait_idle(10);
  endtask

  task automatic test_overflow();
    logic [3:0]       ops [6];
    logic [JDO_W-1:0] dat [6];
    ops = '{4'd6, 4'd7, 4'd8, 4'd0, 4'd1, 4'd2};
    cmd_ready = 1'b0;
    // The first entry moves into the command register, the next four fill the
    // FIFO, and the sixth is dropped.
    for (int i = 0; i < 6; i++) begin
      dat[i] = JDO_W'(38'h100 + i * 38'h11);
      if (i < 5) expect_cmd(ops[i], dat[i]);
      pulse(10'b1 << ops[i], dat[i]);
    end
    @(negedge clk);
    chk("ovf_set", 64'(ovf_sticky), 64'd1);
    chk("ovf_head_held", 64'({cmd_valid, cmd_op, cmd_data}), 64'({1'b1, ops[0], dat[0]}));
    tick();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    @(negedge clk);
    chk("ovf_clr", 64'(ovf_sticky), 64'd0);
    tick();
    cmd_ready = 1'b1;                       // accept head
    tick();
    cmd_ready = 1'b0;                       // IDLE pop while full, plus a push
    stb = 10'b1 << 5;
    jdo = 38'h3_CAFE_F00D;
    expect_cmd(4'd5, 38'h3_CAFE_F00D);
    tick();
    stb = '0;
    @(negedge clk);
    chk("full_pushpop_no_ovf", 64'(ovf_sticky), 64'd0);
    chk("full_pushpop_head", 64'(cmd_op), 64'(ops[1]));
    cmd_ready = 1'b1;
    wait_idle(60);
    chk("ovf_drain_all", 64'(sb.size()), 64'd0);
  endtask

  task automatic test_collision();
    cmd_ready = 1'b1;
    expect_cmd(4'd0, 38'h5555);
    pulse((10'b1 << 0) | (10'b1 << 5), 38'h5555);
    wait_idle(20);
    chk("coll_ovf", 64'(ovf_sticky), 64'd1);
    chk("coll_one_issued", 64'(sb.size()), 64'd0);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
  endtask

  task automatic test_timeout();
    cmd_ready = 1'b1;
    expect_cmd(4'd4, 38'h777);
    pulse(10'b1 << 4, 38'h777);             // N, now N+1
    for (int i = 0; i < 9; i++) tick();     // N+10: 8th WAIT_MON cycle
    @(negedge clk);
    chk("tmo_pending", 64'({tmo_sticky, busy}), 64'b01);
    tick();
    @(negedge clk);
    chk("tmo_fired", 64'({tmo_sticky, busy}), 64'b10);
    // Error and ready together, with clr_status: error wins and its set beats the clear.
    expect_cmd(4'd4, 38'h888);
    pulse(10'b1 << 4, 38'h888);
    tick();
    tick();                                 // WAIT_MON
    monitor_error = 1'b1;
    monitor_ready = 1'b1;
    clr_status    = 1'b1;
    tick();
    monitor_error = 1'b0;
    monitor_ready = 1'b0;
    clr_status    = 1'b0;
    @(negedge clk);
    chk("err_set", 64'({err_sticky, tmo_sticky, busy}), 64'b100);
  endtask

  task automatic test_reset_midop();
    cmd_ready = 1'b1;
    expect_cmd(4'd3, 38'h42);
    pulse(10'b1 << 3, 38'h42);
    pulse(10'b1 << 0, 38'h43);
    pulse(10'b1 << 1, 38'h44);              // now WAIT_MON with 2 queued
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_outputs",
        64'({cmd_valid, cmd_op, busy, ovf_sticky, err_sticky, tmo_sticky}), 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_no_replay", 64'({cmd_valid, busy}), 64'd0);
      tick();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    stb = '0;
    jdo = '0;
    cmd_ready = 1'b0;
    monitor_ready = 1'b0;
    monitor_error = 1'b0;
    clr_status = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    test_reset();
    tick();
    test_latency();
    test_ocimem_wait();
    test_overflow();
    test_collision();
    test_timeout();
    test_reset_midop();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
